rule_stream_arbiter: RTL and testbench

- Packet-atomic round-robin arbiter that merges NUM_LANES 128-bit rule-match streams into one stream.
- Each input stream comes from one string-matcher lane. The output feeds the shared rule depacker and its rule FIFO.
- A grant is held from the accepted sop beat through the accepted eop beat, so packets never interleave.
- Output is registered: one pipeline stage with a full-throughput valid/ready handshake.

---
 rtl/rule_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 36 +++
 rtl/rule_stream_arbiter.sv | 135 +++++++++++++
 tb/tb_rule_stream_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rule_arb_pkg.sv
// Shared types and helpers for the rule-stream lane arbiters.
//   arb_state_t : IDLE (searching for a new packet) / BUSY (grant locked to a lane)
//   lane_w()    : index width for a given lane count, never narrower than 1 bit
package rule_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per lane
//   ptr   : highest-priority lane this cycle (must be < N)
//   found : at least one request is set
//   idx   : first requesting lane at or after ptr, wrapping modulo N
module rr_pick
    import rule_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = lane_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    int pos;

    // Scan offsets from farthest to nearest so the lane closest to ptr
    // overwrites any earlier hit and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int off = N - 1; off >= 0; off--) begin
            pos = int'(ptr) + off;
            if (pos >= N) pos = pos - N;
            if (req[pos]) begin
                found = 1'b1;
                idx   = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/rule_stream_arbiter.sv
// Packet-atomic round-robin merge of NUM_LANES rule-match streams into one
// registered stream feeding the rule depacker.
//   clk, rst           : clock, synchronous active-high reset
//   in_rule_*          : per-lane sop/eop/valid/empty/data, lane i in slice i
//   in_rule_ready      : per-lane ready (combinational)
//   out_rule_*         : merged registered beat plus its source lane
//   out_rule_ready     : downstream ready
//   stat_pkt_cnt       : per-lane 32-bit eop counters, only when
//                        RULE_ARB_STATS_EN is defined
module rule_stream_arbiter
    import rule_arb_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 128,
    parameter int EMPTY_W   = 4,
    localparam int LANE_W   = lane_w(NUM_LANES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LANES-1:0]         in_rule_sop,
    input  logic [NUM_LANES-1:0]         in_rule_eop,
    input  logic [NUM_LANES-1:0]         in_rule_valid,
    input  logic [NUM_LANES*EMPTY_W-1:0] in_rule_empty,
    input  logic [NUM_LANES*DATA_W-1:0]  in_rule_data,
    output logic [NUM_LANES-1:0]         in_rule_ready,
    output logic                         out_rule_sop,
    output logic                         out_rule_eop,
    output logic                         out_rule_valid,
    output logic [EMPTY_W-1:0]           out_rule_empty,
    output logic [DATA_W-1:0]            out_rule_data,
    output logic [LANE_W-1:0]            out_rule_lane,
    input  logic                         out_rule_ready
`ifdef RULE_ARB_STATS_EN
    ,
    output logic [NUM_LANES*32-1:0]      stat_pkt_cnt
`endif
);

    arb_state_t        state, state_nxt;
    logic [LANE_W-1:0] rr_ptr, rr_nxt;
    logic [LANE_W-1:0] grant, grant_nxt;
    logic [LANE_W-1:0] sel, pick_idx;
    logic              pick_found;
    logic              out_free;
    logic              acc;
    logic              acc_eop;

    function automatic logic [LANE_W-1:0] lane_inc(input logic [LANE_W-1:0] x);
        return (x == LANE_W'(NUM_LANES - 1)) ? '0 : x + 1'b1;
    endfunction

    rr_pick #(.N(NUM_LANES)) u_pick (
        .req   (in_rule_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign out_free = !out_rule_valid || out_rule_ready;

    // Nothing is accepted while rst is high so a beat offered during the
    // reset cycle is never half-consumed.
    always_comb begin
        in_rule_ready = '0;
        state_nxt     = state;
        rr_nxt        = rr_ptr;
        grant_nxt     = grant;
        sel           = grant;
        acc           = 1'b0;
        case (state)
            IDLE: begin
                sel = pick_idx;
                if (pick_found && out_free && !rst) begin
                    in_rule_ready[pick_idx] = 1'b1;
                    acc       = 1'b1;
                    grant_nxt = pick_idx;
                    if (in_rule_eop[pick_idx]) rr_nxt = lane_inc(pick_idx);
                    else                       state_nxt = BUSY;
                end
            end
            BUSY: begin
                // A gap in the granted lane's valid just stalls; the grant is kept.
                if (!rst) in_rule_ready[grant] = out_free;
                acc = !rst && out_free && in_rule_valid[grant];
                if (acc && in_rule_eop[grant]) begin
                    state_nxt = IDLE;
                    rr_nxt    = lane_inc(grant);
                end
            end
            default: state_nxt = IDLE;
        endcase
        acc_eop = acc && in_rule_eop[sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            grant          <= '0;
            out_rule_valid <= 1'b0;
            out_rule_sop   <= 1'b0;
            out_rule_eop   <= 1'b0;
            out_rule_empty <= '0;
            out_rule_data  <= '0;
            out_rule_lane  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            grant  <= grant_nxt;
            if (acc) begin
                out_rule_valid <= 1'b1;
                out_rule_sop   <= in_rule_sop[sel];
                out_rule_eop   <= in_rule_eop[sel];
                out_rule_empty <= in_rule_empty[sel*EMPTY_W +: EMPTY_W];
                out_rule_data  <= in_rule_data[sel*DATA_W +: DATA_W];
                out_rule_lane  <= sel;
            end else if (out_rule_ready) begin
                out_rule_valid <= 1'b0;
            end
        end
    end

`ifdef RULE_ARB_STATS_EN
    logic [NUM_LANES-1:0][31:0] pkt_cnt;

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst)          pkt_cnt <= '0;
        else if (acc_eop) pkt_cnt[sel] <= pkt_cnt[sel] + 32'd1;
    end

    assign stat_pkt_cnt = pkt_cnt;
`endif

endmodule

// File: tb/tb_rule_stream_arbiter.sv
// Directed bench for rule_stream_arbiter: per-lane beat queues feed the
// inputs, expected output beats go to a scoreboard in predicted order and
// are popped as the merged stream hands them downstream.
module tb_rule_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int EW = 4;
    localparam int LW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    in_rule_sop   = '0;
    logic [N-1:0]    in_rule_eop   = '0;
    logic [N-1:0]    in_rule_valid = '0;
    logic [N*EW-1:0] in_rule_empty = '0;
    logic [N*DW-1:0] in_rule_data  = '0;
    logic [N-1:0]    in_rule_ready;
    logic            out_rule_sop, out_rule_eop, out_rule_valid;
    logic [EW-1:0]   out_rule_empty;
    logic [DW-1:0]   out_rule_data;
    logic [LW-1:0]   out_rule_lane;
    logic            out_rule_ready = 1'b1;
`ifdef RULE_ARB_STATS_EN
    logic [N*32-1:0] stat_pkt_cnt;
`endif

    rule_stream_arbiter #(.NUM_LANES(N), .DATA_W(DW), .EMPTY_W(EW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_rule_sop    (in_rule_sop),
        .in_rule_eop    (in_rule_eop),
        .in_rule_valid  (in_rule_valid),
        .in_rule_empty  (in_rule_empty),
        .in_rule_data   (in_rule_data),
        .in_rule_ready  (in_rule_ready),
        .out_rule_sop   (out_rule_sop),
        .out_rule_eop   (out_rule_eop),
        .out_rule_valid (out_rule_valid),
        .out_rule_empty (out_rule_empty),
        .out_rule_data  (out_rule_data),
        .out_rule_lane  (out_rule_lane),
        .out_rule_ready (out_rule_ready)
`ifdef RULE_ARB_STATS_EN
        ,
        .stat_pkt_cnt   (stat_pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic [DW-1:0] data;
        logic [LW-1:0] lane;
    } beat_t;

    beat_t        lq[N][$];
    beat_t        sb[$];
    logic [N-1:0] fired = '0;
    logic [N-1:0] hold  = '0;
    int           checks = 0;
    int           errors = 0;
    int           out_cnt = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue a beat on a lane; exp_out also records it as an expected output.
    task automatic push(input int lane, input logic sop, input logic eop,
                        input logic [EW-1:0] empty, input bit exp_out);
        beat_t b;
        b.sop   = sop;
        b.eop   = eop;
        b.empty = empty;
        b.data  = {$urandom, $urandom, $urandom, $urandom};
        b.lane  = LW'(lane);
        lq[lane].push_back(b);
        if (exp_out) sb.push_back(b);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, DW'(sb.size()), DW'(0));
    endtask

    // Lane drivers: retire the head beat after a handshake, present the next.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fired[i] && lq[i].size() > 0) void'(lq[i].pop_front());
            if (lq[i].size() > 0 && !hold[i]) begin
                in_rule_valid[i] = 1'b1;
                in_rule_sop[i]   = lq[i][0].sop;
                in_rule_eop[i]   = lq[i][0].eop;
                in_rule_empty[i*EW +: EW] = lq[i][0].empty;
                in_rule_data[i*DW +: DW]  = lq[i][0].data;
            end else begin
                in_rule_valid[i] = 1'b0;
                in_rule_sop[i]   = 1'b0;
                in_rule_eop[i]   = 1'b0;
            end
        end
    end

    // Handshake capture and output scoreboard.
    always @(negedge clk) begin : mon
        beat_t e;
        fired = in_rule_valid & in_rule_ready;
        if (!rst && out_rule_valid && out_rule_ready) begin
            out_cnt++;
            chk("sb_has_entry", DW'(sb.size() > 0), DW'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_sop",   DW'(out_rule_sop),   DW'(e.sop));
                chk("out_eop",   DW'(out_rule_eop),   DW'(e.eop));
                chk("out_empty", DW'(out_rule_empty), DW'(e.empty));
                chk("out_data",  out_rule_data,       e.data);
                chk("out_lane",  DW'(out_rule_lane),  DW'(e.lane));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        logic [LW-1:0] order2 [5];
        order2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // ---- reset state
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", DW'(out_rule_valid), DW'(0));
        chk("rst_out_sop",   DW'(out_rule_sop),   DW'(0));
        chk("rst_out_data",  out_rule_data,       DW'(0));
        chk("rst_out_lane",  DW'(out_rule_lane),  DW'(0));
        chk("rst_rr_ptr",    DW'(dut.rr_ptr),     DW'(0));

        // ---- single lane 3-beat packet, empties 0,0,5
        @(posedge clk); #2;
        push(0, 1'b1, 1'b0, 4'd0, 1'b1);
        push(0, 1'b0, 1'b0, 4'd0, 1'b1);
        push(0, 1'b0, 1'b1, 4'd5, 1'b1);
        repeat (2) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t1_back_to_back", DW'(out_rule_valid), DW'(1));
            @(posedge clk);
        end
        drain("t1");
        chk("t1_rr_ptr", DW'(dut.rr_ptr), DW'(1));

        // ---- reset, then all lanes with 1-beat packets: 0,1,2,3,0 with no gaps
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        for (int l = 0; l < N; l++) push(l, 1'b1, 1'b1, EW'(l), 1'b1);
        push(0, 1'b1, 1'b1, 4'd9, 1'b1);
        repeat (2) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t2_no_gap",  DW'(out_rule_valid), DW'(1));
            chk("t2_rr_lane", DW'(out_rule_lane),  DW'(order2[k]));
            @(posedge clk);
        end
        drain("t2");
`ifdef RULE_ARB_STATS_EN
        chk("t2_stat0", DW'(stat_pkt_cnt[0*32 +: 32]), DW'(2));
        chk("t2_stat3", DW'(stat_pkt_cnt[3*32 +: 32]), DW'(1));
`endif

        // ---- lane 1 4-beat packet while lane 2 waits (rr_ptr = 1)
        @(posedge clk); #2;
        push(1, 1'b1, 1'b0, 4'd0, 1'b1);
        push(1, 1'b0, 1'b0, 4'd0, 1'b1);
        push(1, 1'b0, 1'b0, 4'd0, 1'b1);
        push(1, 1'b0, 1'b1, 4'd3, 1'b1);
        push(2, 1'b1, 1'b1, 4'd7, 1'b1);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_lane2_blocked", DW'(in_rule_ready[2]), DW'(0));
            @(posedge clk);
        end
        @(negedge clk);
        chk("t3_lane2_granted", DW'(in_rule_ready[2]), DW'(1));
        drain("t3");

        // ---- downstream stall mid-packet (rr_ptr = 3: lane 3, lane 0 x4, lane 1)
        @(posedge clk); #2;
        base = out_cnt;
        push(3, 1'b1, 1'b1, 4'd1, 1'b1);
        push(0, 1'b1, 1'b0, 4'd0, 1'b1);
        push(0, 1'b0, 1'b0, 4'd0, 1'b1);
        push(0, 1'b0, 1'b0, 4'd0, 1'b1);
        push(0, 1'b0, 1'b1, 4'd2, 1'b1);
        push(1, 1'b1, 1'b1, 4'd4, 1'b1);
        n = 0;
        while (out_cnt < base + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_reached_mid", DW'(out_cnt >= base + 3), DW'(1));
        @(posedge clk); #2 out_rule_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_stall_ready", DW'(in_rule_ready),  DW'(0));
            chk("t4_stall_valid", DW'(out_rule_valid), DW'(1));
            chk("t4_stall_data",  out_rule_data,       sb[0].data);
        end
        @(posedge clk); #2 out_rule_ready = 1'b1;
        drain("t4");

        // ---- granted lane 2 drops valid for 3 cycles, lane 0 must wait
        @(posedge clk); #2;
        push(2, 1'b1, 1'b0, 4'd0, 1'b1);
        push(2, 1'b0, 1'b0, 4'd0, 1'b1);
        push(2, 1'b0, 1'b0, 4'd0, 1'b1);
        push(2, 1'b0, 1'b1, 4'd6, 1'b1);
        @(posedge clk); #2;
        @(posedge clk); #2;
        hold[2] = 1'b1;
        push(0, 1'b1, 1'b1, 4'd8, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t5_lane0_blocked", DW'(in_rule_ready[0]), DW'(0));
            if (k > 0) chk("t5_no_beat", DW'(out_rule_valid), DW'(0));
        end
        @(posedge clk); #2 hold[2] = 1'b0;
        drain("t5");

        // ---- reset while BUSY on lane 1
        @(posedge clk); #2;
        push(1, 1'b1, 1'b0, 4'd0, 1'b1);
        push(1, 1'b0, 1'b0, 4'd0, 1'b0);
        push(1, 1'b0, 1'b1, 4'd0, 1'b0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        lq[1].delete();
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("t6_out_valid_cleared", DW'(out_rule_valid), DW'(0));
        chk("t6_ready_low",         DW'(in_rule_ready),  DW'(0));
        chk("t6_rr_ptr",            DW'(dut.rr_ptr),     DW'(0));
        chk("t6_sb_empty",          DW'(sb.size()),      DW'(0));
`ifdef RULE_ARB_STATS_EN
        chk("t6_stats_clear", DW'(stat_pkt_cnt), DW'(0));
`endif
        @(posedge clk); #2;
        push(0, 1'b1, 1'b1, 4'd2, 1'b1);
        push(3, 1'b1, 1'b1, 4'd3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("t6_lane0_wins", DW'(in_rule_ready), DW'(4'b0001));
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
